// File: rtl/alu_8bit.sv
// ---------------------------------------------------------------------------
// alu_8bit
// Eight-operation ALU with a registered result and registered flags.
// The result is formed combinationally from opcode/a/b and captured on every
// rising clk edge (one cycle of latency, no enable).
//
// Ports
//   clk       in   1  sole clock, rising edge
//   rst_n     in   1  asynchronous, active-low reset
//   opcode    in   3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                     101 NOT, 110 SHL, 111 SHR
//   a         in   5  operand A, unsigned, zero-extended to 8 bits
//   b         in   8  operand B, unsigned
//   data_out  out  8  registered result
//   zflag     out  1  registered zero flag (result == 0)
//   c         out  1  registered carry / no-borrow / shift-out flag
// ---------------------------------------------------------------------------
module alu_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [4:0] a,
  input  logic [7:0] b,
  output logic [7:0] data_out,
  output logic       zflag,
  output logic       c
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  logic [7:0] a8;
  logic [2:0] sh_amt;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [8:0] shl9;
  logic [8:0] shr9;

  logic [7:0] data_out_d, data_out_q;
  logic       zflag_d, zflag_q;
  logic       c_d, c_q;

  assign a8     = {3'b000, a};
  assign sh_amt = a[2:0];

  // Ninth bit catches carry-out (add) or borrow (subtract).
  assign sum9  = {1'b0, b} + {1'b0, a8};
  assign diff9 = {1'b0, b} - {1'b0, a8};

  // Shifting through a 9-bit window leaves the last bit shifted out in the
  // extra position: bit 8 for left shifts, bit 0 for right shifts. A zero
  // shift amount leaves that extra bit at its zero fill.
  assign shl9 = {1'b0, b} << sh_amt;
  assign shr9 = {b, 1'b0} >> sh_amt;

  always_comb begin
    data_out_d = 8'h00;
    c_d        = 1'b0;
    case (op_e'(opcode))
      OP_ADD: begin
        data_out_d = sum9[7:0];
        c_d        = sum9[8];
      end
      OP_SUB: begin
        data_out_d = diff9[7:0];
        c_d        = ~diff9[8];
      end
      OP_AND: data_out_d = b & a8;
      OP_OR:  data_out_d = b | a8;
      OP_XOR: data_out_d = b ^ a8;
      OP_NOT: data_out_d = ~b;
      OP_SHL: begin
        data_out_d = shl9[7:0];
        c_d        = shl9[8];
      end
      OP_SHR: begin
        data_out_d = shr9[8:1];
        c_d        = shr9[0];
      end
      default: begin
        data_out_d = 8'h00;
        c_d        = 1'b0;
      end
    endcase
    zflag_d = (data_out_d == 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= 8'h00;
      zflag_q    <= 1'b0;
      c_q        <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      zflag_q    <= zflag_d;
      c_q        <= c_d;
    end
  end

  assign data_out = data_out_q;
  assign zflag    = zflag_q;
  assign c        = c_q;

endmodule

// File: tb/tb_alu_8bit.sv
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [4:0] a = 5'd0;
  logic [7:0] b = 8'h00;
  logic [7:0] data_out;
  logic       zflag;
  logic       c;

  int tests_run = 0;
  int tests_failed = 0;

  alu_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .data_out (data_out),
    .zflag    (zflag),
    .c        (c)
  );

  always #5 clk = ~clk;

  // Drive a vector between edges, then step past the next rising edge.
  task automatic apply(input logic [2:0] op, input logic [4:0] av, input logic [7:0] bv);
    @(negedge clk);
    opcode = op;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    opcode = 3'b000; a = 5'd1; b = 8'h01;
    #2 rst_n = 1'b0;
    #1;
    exp = {8'h00, 1'b0, 1'b0};
    tests_run++;
    if ({data_out, zflag, c} !== exp) begin
      tests_failed++;
      $display("FAIL reset_immediate: got %h/%b/%b want 00/0/0", data_out, zflag, c);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({data_out, zflag, c} !== exp) begin
      tests_failed++;
      $display("FAIL reset_held: got %h/%b/%b want 00/0/0", data_out, zflag, c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({data_out, zflag, c} !== exp) begin
      tests_failed++;
      $display("FAIL reset_release_no_edge: got %h/%b/%b want 00/0/0", data_out, zflag, c);
    end
    @(posedge clk);
    #1;
    exp = {8'h02, 1'b0, 1'b0};
    tests_run++;
    if ({data_out, zflag, c} !== exp) begin
      tests_failed++;
      $display("FAIL first_capture: got %h/%b/%b want 02/0/0", data_out, zflag, c);
    end
  endtask

  task automatic test_add();
    logic [2:0] ops [3] = '{3'b000, 3'b000, 3'b000};
    logic [4:0] as  [3] = '{5'd1, 5'd0, 5'd1};
    logic [7:0] bs  [3] = '{8'h01, 8'h00, 8'hFF};
    logic [9:0] exp [3] = '{{8'h02, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b0}, {8'h00, 1'b1, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      apply(ops[i], as[i], bs[i]);
      tests_run++;
      if ({data_out, zflag, c} !== exp[i]) begin
        tests_failed++;
        $display("FAIL add[%0d]: got %h/%b/%b want %h/%b/%b", i, data_out, zflag, c,
                 exp[i][9:2], exp[i][1], exp[i][0]);
      end
    end
  endtask

  task automatic test_sub();
    logic [4:0] as  [4] = '{5'd5, 5'd6, 5'h1F, 5'd5};
    logic [7:0] bs  [4] = '{8'h05, 8'h05, 8'h00, 8'h20};
    logic [9:0] exp [4] = '{{8'h00, 1'b1, 1'b1}, {8'hFF, 1'b0, 1'b0},
                            {8'hE1, 1'b0, 1'b0}, {8'h1B, 1'b0, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      apply(3'b001, as[i], bs[i]);
      tests_run++;
      if ({data_out, zflag, c} !== exp[i]) begin
        tests_failed++;
        $display("FAIL sub[%0d]: got %h/%b/%b want %h/%b/%b", i, data_out, zflag, c,
                 exp[i][9:2], exp[i][1], exp[i][0]);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0] ops [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b010};
    logic [4:0] as  [6] = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h00, 5'h0F};
    logic [7:0] bs  [6] = '{8'hF0, 8'hE0, 8'hF0, 8'hFF, 8'h5A, 8'hF0};
    logic [9:0] exp [6] = '{{8'h10, 1'b0, 1'b0}, {8'hFF, 1'b0, 1'b0},
                            {8'hEF, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b0},
                            {8'hA5, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      apply(ops[i], as[i], bs[i]);
      tests_run++;
      if ({data_out, zflag, c} !== exp[i]) begin
        tests_failed++;
        $display("FAIL logic[%0d]: got %h/%b/%b want %h/%b/%b", i, data_out, zflag, c,
                 exp[i][9:2], exp[i][1], exp[i][0]);
      end
    end
  endtask

  task automatic test_shift();
    logic [2:0] ops [7] = '{3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b111, 3'b111};
    logic [4:0] as  [7] = '{5'd3, 5'b11000, 5'b01111, 5'd1, 5'd7, 5'd2, 5'b10000};
    logic [7:0] bs  [7] = '{8'hB1, 8'h81, 8'h03, 8'h03, 8'h80, 8'h02, 8'h81};
    logic [9:0] exp [7] = '{{8'h88, 1'b0, 1'b1}, {8'h81, 1'b0, 1'b0},
                            {8'h80, 1'b0, 1'b1}, {8'h01, 1'b0, 1'b1},
                            {8'h01, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b1},
                            {8'h81, 1'b0, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      apply(ops[i], as[i], bs[i]);
      tests_run++;
      if ({data_out, zflag, c} !== exp[i]) begin
        tests_failed++;
        $display("FAIL shift[%0d]: got %h/%b/%b want %h/%b/%b", i, data_out, zflag, c,
                 exp[i][9:2], exp[i][1], exp[i][0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Each cycle must reflect only the vector presented before that edge.
    apply(3'b000, 5'd3, 8'h10);
    tests_run++;
    if ({data_out, zflag, c} !== {8'h13, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_0: got %h/%b/%b want 13/0/0", data_out, zflag, c);
    end
    apply(3'b001, 5'd4, 8'h03);
    tests_run++;
    if ({data_out, zflag, c} !== {8'hFF, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_1: got %h/%b/%b want ff/0/0", data_out, zflag, c);
    end
    apply(3'b100, 5'h0A, 8'h0A);
    tests_run++;
    if ({data_out, zflag, c} !== {8'h00, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_2: got %h/%b/%b want 00/1/0", data_out, zflag, c);
    end
  endtask

  task automatic test_mid_reset();
    apply(3'b000, 5'd1, 8'hFF);
    apply(3'b001, 5'd2, 8'h80);
    tests_run++;
    if ({data_out, zflag, c} !== {8'h7E, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_reset_pre: got %h/%b/%b want 7e/0/1", data_out, zflag, c);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({data_out, zflag, c} !== {8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_reset_immediate: got %h/%b/%b want 00/0/0", data_out, zflag, c);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({data_out, zflag, c} !== {8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_reset_override: got %h/%b/%b want 00/0/0", data_out, zflag, c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({data_out, zflag, c} !== {8'h7E, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_reset_recover: got %h/%b/%b want 7e/0/1", data_out, zflag, c);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the end, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_8bit.md
ALU_8BIT -- requirements
Module: alu_8bit

Interface
Parameters: none; widths are fixed.
REQ-001 The module SHALL have these ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  3  operation select.
- a  input  5  operand A, unsigned; zero-extended to 8 bits before use.
- b  input  8  operand B, unsigned.
- data_out  output  8  registered result.
- zflag  output  1  registered zero flag.
- c  output  1  registered carry/no-borrow/shift-out flag.

REQ-002 The design SHALL have one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-003 The result SHALL be computed combinationally from opcode, a and b, and captured into data_out, zflag and c on each rising clk edge.
- Latency: exactly 1 cycle.
- No enable; a new result is captured every cycle.

REQ-004 Let A8 = {3'b000, a}. All arithmetic SHALL be 8-bit with a 9th bit for carry.

REQ-005 Opcode 000 ADD:
- data_out = (b + A8) mod 256.
- c = bit 8 of the 9-bit sum.

REQ-006 Opcode 001 SUB:
- data_out = (b - A8) mod 256.
- c = 1 when b >= A8 (no borrow), else 0.

REQ-007 Opcodes 010/011/100 (AND/OR/XOR): data_out = b & A8 / b | A8 / b ^ A8; c = 0.

REQ-008 Opcode 101 NOT: data_out = ~b; a is ignored; c = 0.

REQ-009 Opcode 110 SHL:
- data_out = b << a[2:0], zero-fill; a[4:3] ignored.
- c = b[8 - a[2:0]] when a[2:0] != 0, else 0.

REQ-010 Opcode 111 SHR:
- data_out = b >> a[2:0], logical, zero-fill.
- c = b[a[2:0] - 1] when a[2:0] != 0, else 0.

REQ-011 zflag SHALL be 1 exactly when the next data_out value is 8'h00, for every opcode.

REQ-012 Boundaries:
- ADD 0xFF + 1 = 0x00, c=1, zflag=1.
- SUB 0x00 - 0x1F = 0xE1, c=0.
- SUB with equal operands = 0x00, c=1, zflag=1.

REQ-013 Outputs SHALL never be X/Z after reset when inputs are known.

Reset
REQ-014 While rst_n = 0, outputs SHALL be data_out = 8'h00, zflag = 0, c = 0, immediately and without waiting for a clk edge.

REQ-015 Reset asserted mid-operation SHALL override any pending capture.

REQ-016 The first capture SHALL occur on the first rising clk edge after rst_n deasserts.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- ADD: opcode=000, a=00001, b=0x01 -> next edge: data_out=0x02, zflag=0, c=0.
- ADD zero: opcode=000, a=0, b=0x00 -> data_out=0x00, zflag=1, c=0.
- ADD overflow: a=1, b=0xFF -> data_out=0x00, zflag=1, c=1.
- SUB equal: opcode=001, a=00101, b=0x05 -> data_out=0x00, zflag=1, c=1.
- SUB underflow: opcode=001, a=00110, b=0x05 -> data_out=0xFF, zflag=0, c=0.
- Shifts and reset:
  - SHL a=3, b=0xB1 -> data_out=0x88, c=1.
  - SHR a=1, b=0x03 -> data_out=0x01, c=1.
  - Assert rst_n=0 between edges -> outputs 0x00/0/0 immediately.
